prio_encoder_hs: RTL and testbench
==================================

Name: prio_encoder_hs

Overview:
- Registered 4-to-2 (parameterisable N-to-log2N) priority encoder. It is the inverse of the existing enabled 2-to-4 decoder.
- Captures request pulses into sticky pending bits and presents the highest-priority pending index over a valid/ready handshake.
- Clears each pending bit when its index is accepted.
- Sits between request sources (interrupt/event lines) and a consumer that may later drive the decoder.

Parameters:
- N, 4, number of request lines (≥2).
- W, $clog2(N), width of encoded index (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable; when low, no new index is presented.
- req  input  N  request pulses; bit i set for ≥1 cycle marks line i pending.
- idx  output  W  encoded index of the presented request.
- idx_valid  output  1  idx is valid.
- idx_ready  input  1  consumer accepts idx when high together with idx_valid.
- pending  output  N  current sticky pending vector (status).
- ovf  output  1  one-cycle pulse: req[i] seen while pending[i] already set.

Behaviour:
- Reset (rst_n low, async): pending=0, idx=0, idx_valid=0, ovf=0, state=IDLE. Reset mid-handshake drops the presented index and all pending bits.
- Pending update, every clock: pending_next = (pending & ~clr) | req.
  - clr is onehot(idx) on an accept cycle, otherwise 0.
  - A new req on the same bit as clr wins: the bit stays set.
- ovf_next = |(req & pending & ~clr). Registered, so high for exactly one cycle per offending cycle.
- Priority: highest set index wins (bit N-1 highest).
- State IDLE:
  - If en=1 and pending≠0 (registered value): load idx=highest set bit of pending, set idx_valid=1, go to PRESENT.
  - Latency: req high at edge k sets pending at k; idx_valid is high after edge k+1.
- State PRESENT:
  - idx and idx_valid are held stable while idx_ready=0, regardless of en or new reqs. A higher-priority arrival does not pre-empt the presented index.
  - On accept (idx_valid & idx_ready), let rem = pending & ~onehot(idx). Same-cycle reqs are excluded; they become visible next cycle.
  - If en=1 and rem≠0: load idx=highest bit of rem, keep idx_valid=1, stay in PRESENT. This gives back-to-back transfers with no bubble.
  - Otherwise: idx_valid=0, go to IDLE. idx holds its last value.
- en low while PRESENT: the current transfer completes; no further loads until en=1.
- idx is don't-care when idx_valid=0, but must be driven from a register (no X).
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (decoder_pkg):
  - State enum {IDLE, PRESENT}.
  - Function clog2.
  - Function onehot(idx) → N-bit mask. The decoder can reuse this.
- One natural sub-module: prio_find (combinational). Input N-bit vector; outputs W-bit highest-set index and any-set flag. Instantiated twice, on pending and on rem.
- Top holds the pending register, the FSM and the ovf register.

Test Plan:
- Reset/idle: rst_n=0 → all outputs 0. Release with req=0, en=1 → idx_valid stays 0 for 10 cycles.
- Single request: en=1, req=4'b0100 for 1 cycle, idx_ready=1 → idx_valid high 2 cycles after req sampled, idx=2 for 1 cycle; pending returns to 0.
- Priority and back-to-back: req=4'b1011 one cycle, idx_ready=1 → idx sequence 3,1,0 on consecutive cycles, then idx_valid=0.
- Backpressure: req=4'b0001, idx_ready=0 for 5 cycles, then req=4'b1000 → idx stays 0 and valid stays high. Raise idx_ready → idx=0 accepted, next cycle idx=3.
- Enable gating: en=0, req=4'b0010 → pending=4'b0010, idx_valid=0. Set en=1 → idx=1 valid on the next cycle.
- Overflow and clear/set collision: req[1] pulsed twice while pending[1]=1 → ovf pulses once per repeat. req[1] high on the cycle idx=1 is accepted → pending[1] remains 1 and idx=1 is presented again.
- Async reset mid-transfer: drop rst_n while idx_valid=1 → idx_valid=0 and pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prio_encoder_hs_pkg.sv
// Shared types and helpers for the priority encoder.
// The matching decoder can reuse the onehot() helper.
package prio_encoder_hs_pkg;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  // Widest request vector that onehot() can produce a mask for.
  localparam int MAX_N = 64;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned index);
    logic [MAX_N-1:0] one;
    one = {{(MAX_N-1){1'b0}}, 1'b1};
    return one << index;
  endfunction

endpackage

// File: rtl/prio_encoder_hs_find.sv
// Combinational highest-set-bit finder.
// Bit N-1 has the highest priority.
module prio_find
  import prio_encoder_hs_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] index,
  output logic         found
);

  // The ascending scan lets higher bits overwrite lower ones.
  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        index = W'(i);
      end
    end
  end

  assign found = |vec;

endmodule

// File: rtl/prio_encoder_hs.sv
// Registered N-to-log2(N) priority encoder with sticky pending bits and a
// valid/ready handshake on the presented index.
module prio_encoder_hs
  import prio_encoder_hs_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [N-1:0] pending,
  output logic         ovf
);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] idx_next;
  logic         valid_next;

  logic         accept;
  logic [N-1:0] idx_mask;
  logic [N-1:0] clr;
  logic [N-1:0] rem;
  logic [W-1:0] pend_idx;
  logic         pend_any;
  logic [W-1:0] rem_idx;
  logic         rem_any;

  assign accept   = idx_valid & idx_ready;
  assign idx_mask = N'(onehot(32'(idx)));
  assign clr      = accept ? idx_mask : '0;
  // Same-cycle requests are deliberately left out so they surface next cycle.
  assign rem      = pending & ~idx_mask;

  prio_find #(.N(N)) find_pending (
    .vec   (pending),
    .index (pend_idx),
    .found (pend_any)
  );

  prio_find #(.N(N)) find_rem (
    .vec   (rem),
    .index (rem_idx),
    .found (rem_any)
  );

  // A request arriving on the bit being cleared wins, so it stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | req;
      ovf     <= |(req & pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      idx_valid <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      idx_valid <= valid_next;
    end
  end

  // The presented index is never pre-empted; it only changes on accept.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    valid_next = idx_valid;
    case (state)
      IDLE: begin
        if (en && pend_any) begin
          idx_next   = pend_idx;
          valid_next = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          if (en && rem_any) begin
            idx_next   = rem_idx;
            valid_next = 1'b1;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Directed scoreboard bench for prio_encoder_hs (N=4): expected indices are
// queued as requests are driven and popped as transfers are accepted.
module tb_prio_encoder_hs;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [1:0] idx;
  logic       idx_valid;
  logic       idx_ready;
  logic [3:0] pending;
  logic       ovf;

  int checks;
  int errors;
  int exp_q[$];

  prio_encoder_hs #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .pending   (pending),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // Pops one expected index per accepted transfer; budget bounds the wait.
  task automatic drain(input string tag, input int budget);
    int n;
    int e;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (idx_valid && idx_ready) begin
        e = exp_q.pop_front();
        check_output(tag, 32'(idx), e);
      end
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      check_output({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    req       = 4'b0000;
    idx_ready = 1'b0;

    // Reset and idle
    #1;
    check_output("rst_valid", 32'(idx_valid), 0);
    check_output("rst_idx", 32'(idx), 0);
    check_output("rst_pending", 32'(pending), 0);
    check_output("rst_ovf", 32'(ovf), 0);
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_output("idle_valid", 32'(idx_valid), 0);
    end

    // Single request
    idx_ready = 1'b1;
    req = 4'b0100;
    step();
    req = 4'b0000;
    check_output("single_pending", 32'(pending), 32'h4);
    check_output("single_early_valid", 32'(idx_valid), 0);
    exp_q.push_back(2);
    step();
    check_output("single_valid", 32'(idx_valid), 1);
    drain("single_idx", 1);
    check_output("single_done_valid", 32'(idx_valid), 0);
    check_output("single_done_pending", 32'(pending), 0);

    // Priority and back-to-back
    req = 4'b1011;
    step();
    req = 4'b0000;
    exp_q.push_back(3);
    exp_q.push_back(1);
    exp_q.push_back(0);
    step();
    drain("b2b_idx", 3);
    check_output("b2b_done_valid", 32'(idx_valid), 0);
    check_output("b2b_done_pending", 32'(pending), 0);

    // Backpressure
    idx_ready = 1'b0;
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    for (int i = 0; i < 5; i++) begin
      check_output("bp_hold_valid", 32'(idx_valid), 1);
      check_output("bp_hold_idx", 32'(idx), 0);
      step();
    end
    req = 4'b1000;
    step();
    req = 4'b0000;
    check_output("bp_nopreempt_idx", 32'(idx), 0);
    check_output("bp_nopreempt_valid", 32'(idx_valid), 1);
    check_output("bp_pending", 32'(pending), 32'h9);
    idx_ready = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(3);
    drain("bp_idx", 2);
    check_output("bp_done_valid", 32'(idx_valid), 0);

    // Enable gating
    en  = 1'b0;
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    step();
    check_output("en_pending", 32'(pending), 32'h2);
    check_output("en_gated_valid", 32'(idx_valid), 0);
    en = 1'b1;
    step();
    check_output("en_valid", 32'(idx_valid), 1);
    exp_q.push_back(1);
    drain("en_idx", 1);
    check_output("en_done_pending", 32'(pending), 0);

    // Overflow and clear/set collision
    idx_ready = 1'b0;
    req = 4'b0010;
    step();
    req = 4'b0000;
    check_output("ovf_first", 32'(ovf), 0);
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    check_output("ovf_pulse1", 32'(ovf), 1);
    step();
    check_output("ovf_low1", 32'(ovf), 0);
    req = 4'b0010;
    step();
    req = 4'b0000;
    check_output("ovf_pulse2", 32'(ovf), 1);
    step();
    check_output("ovf_low2", 32'(ovf), 0);
    check_output("col_pre_idx", 32'(idx), 1);
    idx_ready = 1'b1;
    req = 4'b0010;
    step();
    req = 4'b0000;
    check_output("col_pending", 32'(pending), 32'h2);
    check_output("col_ovf", 32'(ovf), 0);
    check_output("col_gap_valid", 32'(idx_valid), 0);
    step();
    check_output("col_again_valid", 32'(idx_valid), 1);
    exp_q.push_back(1);
    drain("col_idx", 1);
    check_output("col_done_pending", 32'(pending), 0);

    // Asynchronous reset mid-transfer
    idx_ready = 1'b0;
    req = 4'b1000;
    step();
    req = 4'b0100;
    step();
    req = 4'b0000;
    check_output("ar_pre_valid", 32'(idx_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("ar_valid", 32'(idx_valid), 0);
    check_output("ar_pending", 32'(pending), 0);
    check_output("ar_idx", 32'(idx), 0);
    step();
    rst_n = 1'b1;
    step();
    check_output("ar_after_valid", 32'(idx_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
